// File: rtl/pin_write_arbiter.sv
// pin_write_arbiter: round-robin arbiter sharing the PIO pin write port and sticky side-set among state machines.
// Optional conflict statistics counter is built when PIN_ARB_STATS_EN is defined.
module pin_write_arbiter #(
  parameter int NUM_SM = 4,
  parameter int CFG_W  = 9
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_SM-1:0]       sm_enable,
  input  logic [NUM_SM-1:0]       req,
  input  logic [NUM_SM*32-1:0]    req_data,
  input  logic [NUM_SM*CFG_W-1:0] req_base,
  input  logic [NUM_SM*CFG_W-1:0] req_count,
  output logic [NUM_SM-1:0]       ack,
  input  logic [NUM_SM-1:0]       side_en,
  input  logic [NUM_SM-1:0]       side_val,
  output logic [31:0]             write_data,
  output logic                    write_enable,
  output logic [CFG_W-1:0]        cfg_outBase,
  output logic [CFG_W-1:0]        cfg_outCount,
  output logic                    sideSet
`ifdef PIN_ARB_STATS_EN
  ,
  output logic [15:0]             conflict_count
`endif
);
  localparam int PW = $clog2(NUM_SM);
  logic [NUM_SM-1:0] elig;
  logic [PW-1:0]     ptr_q, ptr_d, win;
  logic              found;
  logic [31:0]       write_data_q, write_data_d;
  logic [CFG_W-1:0]  base_q, base_d, count_q, count_d, win_count;
  logic              we_q, we_d, side_q, side_d;
  assign elig = req & sm_enable;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_SM; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_SM;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    win_count    = req_count[CFG_W*int'(win) +: CFG_W];
    ack          = (found && reset_n) ? NUM_SM'(1) << win : '0;
    we_d         = found;
    ptr_d        = found ? win : ptr_q;
    write_data_d = found ? req_data[32*int'(win) +: 32] : write_data_q;
    base_d       = found ? req_base[CFG_W*int'(win) +: CFG_W] : base_q;
    count_d      = found ? (win_count > CFG_W'(32) ? CFG_W'(32) : win_count) : count_q;
  end
  // Downward scan leaves the lowest strobing index as the winner.
  always_comb begin
    side_d = side_q;
    for (int i = NUM_SM - 1; i >= 0; i--)
      if (side_en[i]) side_d = side_val[i];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= PW'(NUM_SM - 1);
      write_data_q <= '0;
      base_q       <= '0;
      count_q      <= '0;
      we_q         <= 1'b0;
      side_q       <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      write_data_q <= write_data_d;
      base_q       <= base_d;
      count_q      <= count_d;
      we_q         <= we_d;
      side_q       <= side_d;
    end
  end
  assign write_data   = write_data_q;
  assign write_enable = we_q;
  assign cfg_outBase  = base_q;
  assign cfg_outCount = count_q;
  assign sideSet      = side_q;
`ifdef PIN_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  always_comb conflict_d = ($countones(elig) >= 2 && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) conflict_q <= '0;
    else conflict_q <= conflict_d;
  end
  assign conflict_count = conflict_q;
`endif
endmodule

// File: doc/pin_write_arbiter.md
# pin_write_arbiter

Round-robin arbiter that shares the single PIO pin bank between several state machines. Each state machine posts out-pin write requests (data, base, count) and side-set updates. The arbiter grants one write per cycle and drives the pin block's write port (`write_data`, `write_enable`, `cfg_outBase`, `cfg_outCount`) plus the sticky `sideSet` level from registers. It sits between the state-machine array and the pin block.

## Interface

Parameters:
- `NUM_SM`, default 4: number of requesting state machines (2..8).
- `CFG_W`, default 9: width of base/count fields, matching the pin block's config ports.

Ports:
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sm_enable` in NUM_SM: requests from a state machine whose bit is 0 are ignored.
- `req` in NUM_SM: per-SM out-write request; held high until acked.
- `req_data` in NUM_SM*32: per-SM write data; SM i occupies bits [32i+31:32i].
- `req_base` in NUM_SM*CFG_W: per-SM out base.
- `req_count` in NUM_SM*CFG_W: per-SM out count.
- `ack` out NUM_SM: one-hot grant, combinational, same cycle as the winning `req`.
- `side_en` in NUM_SM: per-SM side-set update strobe (single cycle, no handshake).
- `side_val` in NUM_SM: per-SM side-set value.
- `write_data` out 32: to pin block.
- `write_enable` out 1: to pin block; one-cycle pulse per granted write.
- `cfg_outBase` out CFG_W: to pin block.
- `cfg_outCount` out CFG_W: to pin block.
- `sideSet` out 1: to pin block pin 31.
- `conflict_count` out 16: present only with `PIN_ARB_STATS_EN`.

## Operation

- Eligible set E = `req & sm_enable`.
- Register `ptr` (index of the last winner) resets to NUM_SM-1, so SM0 has first priority after reset.
- Winner: the first index in E, scanning circularly from ptr+1. `ack[winner]`=1 combinationally. All other `ack` bits are 0. `ack` is all-zero when E is empty or `reset_n`=0.
- On the clock edge after a grant:
  - `write_data` and `cfg_outBase` load the winner's fields.
  - `cfg_outCount` loads min(`req_count`, 32).
  - `write_enable`=1 and `ptr`=winner.
- With no grant: `write_enable`=0, and the data, base, count and `ptr` registers hold.
- Requester contract: drop `req`, or present the next request, on the edge where `ack` was high. A `req` still high in the following cycle is a new request.
- Side-set: the lowest index i with `side_en[i]`=1 wins. `sideSet` is registered to `side_val[i]` on the next edge. `sideSet` is sticky (holds with no strobe). It is independent of the write arbitration and of `sm_enable`.
- Starvation bound: a continuously eligible SM is granted within NUM_SM cycles of asserting `req`.
- Dropping `sm_enable[i]` while `req[i]` is pending removes SM i from E immediately. No ack is issued and no state changes.

## Timing

- Grant latency: `ack` in cycle t; `write_enable` and fields valid in cycle t+1 (one register stage).
- Throughput: one write per cycle. Back-to-back grants produce back-to-back `write_enable` pulses.
- Side-set latency: strobe in cycle t, `sideSet` updated in cycle t+1.
- Reset values: `write_data`=0, `cfg_outBase`=0, `cfg_outCount`=0, `write_enable`=0, `sideSet`=0, `ptr`=NUM_SM-1, `conflict_count`=0.
- Reset asserted mid-operation:
  - All registers clear asynchronously and `ack` forces 0.
  - A grant in the cycle reset asserts is lost; the requester re-requests.
- Release: the first grant is evaluated in the first cycle with `reset_n`=1.

## Configuration

- `PIN_ARB_STATS_EN` defined:
  - `conflict_count` exists.
  - It increments by 1 on every cycle with popcount(E) ≥ 2.
  - It saturates at 16'hFFFF and resets to 0.
- Not defined: the port and counter are absent. Arbitration behaviour is identical.

## Test plan

- Reset, then SM2 alone requests data 32'hA5A5_0001, base 4, count 8 -> `ack`=4'b0100 same cycle. Next cycle: `write_enable`=1, `write_data`=32'hA5A5_0001, `cfg_outBase`=4, `cfg_outCount`=8, `ptr`=2.
- All four SMs request continuously from reset -> grant order 0,1,2,3,0,…. `write_enable` is high every cycle. With the macro defined, `conflict_count` increments every cycle.
- SM1 `req_count`=40 -> `cfg_outCount`=32.
- SM0 and SM3 strobe `side_en` with values 1 and 0 simultaneously -> `sideSet`=1 next cycle, and it stays 1 for 10 idle cycles.
- SM3 requesting with `sm_enable[3]`=0 for 5 cycles -> no `ack`, `write_enable` stays 0. Setting `sm_enable[3]`=1 -> `ack[3]` that cycle.
- Assert `reset_n` low in the cycle of a grant to SM1 -> `ack`=0 and no `write_enable` pulse. After release, SM1 still requesting is granted first only if no SM0 request is pending (`ptr`=NUM_SM-1).
